npc_fetch: RTL and testbench
============================

# npc_fetch

Sequential next-PC and instruction-fetch unit for the multi-cycle core. It holds the architectural PC and fetches each instruction from instruction memory over a request/grant/response handshake, then presents the instruction to the decode/control logic. When the core signals that execution is complete, it consumes the decoder's `npc_op` together with `imm` and `rd1` to compute the next PC. It sits between the instruction ROM and the controller and replaces the free-running combinational PC/NPC pair.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded at reset.
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `npc_op`  in  2  Next-PC select from the controller: `PC_4`, `PC_IMM`, `RD1_IMM`.
- `imm`  in  32  Sign-extended immediate from SEXT.
- `rd1`  in  32  Register-file read port 1.
- `exec_done`  in  1  One-cycle pulse: the current instruction has finished, and `npc_op`/`imm`/`rd1` are valid this cycle.
- `pc`  out  32  Address of the instruction currently held.
- `pc4`  out  32  Equal to `pc`+4; used for JAL/JALR write-back.
- `inst`  out  32  Held instruction word.
- `inst_valid`  out  1  `inst` is valid for the current `pc`.
- `irom_req`  out  1  Fetch request.
- `irom_addr`  out  32  Fetch address; always equal to `pc`.
- `irom_gnt`  in  1  Request accepted this cycle.
- `irom_rvalid`  in  1  Response data valid.
- `irom_rdata`  in  32  Response data.
- `misalign`  out  1  Sticky misaligned-target flag. Tied to 0 when the check is compiled out (see Configuration).

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, and TRAP (TRAP exists only with the macro).
- IDLE: entered during reset. Moves to REQ on the first clock after `rst_n` rises.
- REQ:
  - `irom_req`=1.
  - When `irom_gnt`=1, move to WAIT.
  - `irom_req` stays high until granted.
- WAIT:
  - `irom_req`=0.
  - On `irom_rvalid`: register `irom_rdata` into `inst`, set `inst_valid`, and move to HOLD.
- HOLD:
  - `inst` and `pc` are stable.
  - On `exec_done`: load `pc` with npc, clear `inst_valid`, and move to REQ.
- npc computation, all arithmetic 32-bit modulo 2^32:
  - `PC_4` → `pc`+4.
  - `PC_IMM` → `pc`+`imm`.
  - `RD1_IMM` → (`rd1`+`imm`) with bit 0 cleared.
  - Encoding 2'b11 → `pc`+4.
- `pc4` is registered alongside `pc` and always equals `pc`+4 (wraps 32'hFFFF_FFFC → 32'h0).
- Ignored events:
  - `exec_done` outside HOLD.
  - `irom_rvalid` outside WAIT.
  - `irom_gnt` outside REQ.
- Reset mid-operation: returns to IDLE regardless of state. The memory responder shares `rst_n` and must drop any outstanding response.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `pc4`=`RESET_PC`+4.
  - `inst`=32'h0000_0013 (NOP).
  - `inst_valid`=0, `irom_req`=0, `misalign`=0.
  - State = IDLE.
- `irom_req` is decoded from the registered state only; there is no combinational path from inputs to it.
- Minimum fetch sequence, with `exec_done` at cycle t:
  - t+1: `irom_req`=1 and the new `pc` is visible.
  - If `irom_gnt`=1 at t+1 and `irom_rvalid`=1 at t+2, then `inst_valid`=1 at t+3.
- First fetch after reset release: `irom_req` asserts in the second cycle after `rst_n` rises.
- `irom_rvalid` is never expected in the same cycle as `irom_gnt`. Wait states of any length are tolerated.
- `inst_valid` is 0 from the cycle after `exec_done` until the response is captured.

## Configuration
- `MISALIGN_CHECK_EN` defined:
  - On `exec_done` with npc[1:0]≠0, `pc` is not updated and the FSM moves to TRAP.
  - TRAP: `misalign`=1, `inst_valid`=0, no further requests. Only reset leaves TRAP.
- `MISALIGN_CHECK_EN` undefined:
  - npc[1:0] is forced to 2'b00.
  - `misalign` is constant 0 and there is no TRAP state.

## Structure
- `PC_4`/`PC_IMM`/`RD1_IMM` encodings live in the shared `param.v` header, which is the same header the controller uses.
- FSM state encodings and the NOP constant are also added to `param.v`.
- One sub-module, `npc_calc`: a purely combinational next-PC adder/mux including bit-0 clearing. The FSM and all registers stay in `npc_fetch`.

## Test plan
- Reset release with `irom_gnt`=1 at first request and `irom_rvalid`=1 with rdata 32'h0050_0093 one cycle later → `irom_addr`=0, then `inst`=32'h0050_0093 and `inst_valid`=1, then held until `exec_done`.
- In HOLD, `exec_done` with `PC_4` at `pc`=32'h10 → next `irom_addr`=32'h14, `pc4`=32'h18, `inst_valid` low for exactly 2 cycles with 0-wait memory.
- `PC_IMM` with `imm`=32'hFFFF_FFF8 at `pc`=32'h20 → `pc`=32'h18. `RD1_IMM` with `rd1`=32'h101, `imm`=4 → `pc`=32'h104.
- `irom_gnt` withheld 3 cycles, then `irom_rvalid` delayed 4 cycles; spurious `exec_done` and `irom_rvalid` injected in REQ → `irom_req` held, `pc` unchanged, only the WAIT-state data captured.
- `rst_n` asserted during WAIT → all outputs at reset values immediately, with no capture of a later `irom_rvalid`.
- With `MISALIGN_CHECK_EN`: `PC_IMM`, `imm`=6, `pc`=32'h40 → `misalign`=1, `pc` stays 32'h40, `irom_req` stays 0 until reset. Without the macro: `pc`=32'h44.

Source files
------------

// File: rtl/npc_fetch_pkg.sv
// npc_fetch_pkg: next-PC select encodings, fetch FSM state codes and the NOP word.
package npc_fetch_pkg;
    localparam logic [1:0] PC_4    = 2'b00;
    localparam logic [1:0] PC_IMM  = 2'b01;
    localparam logic [1:0] RD1_IMM = 2'b10;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_TRAP = 3'd4;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/npc_calc.sv
// npc_calc: combinational next-PC adder/mux; the register-indirect target has bit 0 cleared.
module npc_calc
    import npc_fetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [1:0]  i_npc_op,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rd1,
    output logic [31:0] o_npc
);
    logic [31:0] w_rd1_imm;
    assign w_rd1_imm = i_rd1 + i_imm;
    assign o_npc = (i_npc_op == PC_IMM)  ? i_pc + i_imm :
                   (i_npc_op == RD1_IMM) ? {w_rd1_imm[31:1], 1'b0} :
                                           i_pc + 32'd4;
endmodule

// File: rtl/npc_fetch.sv
// npc_fetch: PC register plus request/grant/response instruction fetch FSM.
// Define MISALIGN_CHECK_EN to trap on misaligned next-PC instead of forcing word alignment.
module npc_fetch
    import npc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  i_npc_op,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rd1,
    input  logic        i_exec_done,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic [31:0] o_inst,
    output logic        o_inst_valid,
    output logic        o_irom_req,
    output logic [31:0] o_irom_addr,
    input  logic        i_irom_gnt,
    input  logic        i_irom_rvalid,
    input  logic [31:0] i_irom_rdata,
    output logic        o_misalign
);
    logic [2:0]  r_state;
    logic [31:0] r_pc, r_pc4, r_inst;
    logic        r_inst_valid;
    logic [31:0] w_npc, w_pc_next;

    npc_calc u_npc_calc (
        .i_pc     (r_pc),
        .i_npc_op (i_npc_op),
        .i_imm    (i_imm),
        .i_rd1    (i_rd1),
        .o_npc    (w_npc)
    );

    assign w_pc_next    = w_npc & ~32'h3;
    assign o_pc         = r_pc;
    assign o_pc4        = r_pc4;
    assign o_inst       = r_inst;
    assign o_inst_valid = r_inst_valid;
    assign o_irom_req   = (r_state == S_REQ);
    assign o_irom_addr  = r_pc;

`ifdef MISALIGN_CHECK_EN
    logic r_misalign;
    assign o_misalign = r_misalign;
`else
    assign o_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_pc4        <= RESET_PC + 32'd4;
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            r_misalign   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ:  r_state <= i_irom_gnt ? S_WAIT : S_REQ;
                S_WAIT: if (i_irom_rvalid) begin
                    r_inst       <= i_irom_rdata;
                    r_inst_valid <= 1'b1;
                    r_state      <= S_HOLD;
                end
                S_HOLD: if (i_exec_done) begin
                    r_inst_valid <= 1'b0;
`ifdef MISALIGN_CHECK_EN
                    if (|w_npc[1:0]) begin
                        r_misalign <= 1'b1;
                        r_state    <= S_TRAP;
                    end else begin
                        r_pc    <= w_pc_next;
                        r_pc4   <= w_pc_next + 32'd4;
                        r_state <= S_REQ;
                    end
`else
                    r_pc    <= w_pc_next;
                    r_pc4   <= w_pc_next + 32'd4;
                    r_state <= S_REQ;
`endif
                end
                default: r_state <= r_state;
            endcase
        end
    end
endmodule

// File: tb/tb_npc_fetch.sv
// tb_npc_fetch: directed fetch/next-PC vectors with hand-computed expectations.
module tb_npc_fetch;
    import npc_fetch_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic [31:0] imm = '0, rd1 = '0, rdata = '0;
    logic        exec_done = 1'b0, gnt = 1'b0, rvalid = 1'b0;
    logic [31:0] pc, pc4, inst, addr, last;
    logic        inst_valid, req, misalign;
    int          checks = 0, errors = 0;

    npc_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_npc_op      (npc_op),
        .i_imm         (imm),
        .i_rd1         (rd1),
        .i_exec_done   (exec_done),
        .o_pc          (pc),
        .o_pc4         (pc4),
        .o_inst        (inst),
        .o_inst_valid  (inst_valid),
        .o_irom_req    (req),
        .o_irom_addr   (addr),
        .i_irom_gnt    (gnt),
        .i_irom_rvalid (rvalid),
        .i_irom_rdata  (rdata),
        .o_misalign    (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] d);
        gnt = 1'b1;
        step;
        gnt = 1'b0;
        rvalid = 1'b1;
        rdata = d;
        step;
        rvalid = 1'b0;
        last = d;
    endtask

    task automatic exec(input logic [1:0] op, input logic [31:0] im, input logic [31:0] r1);
        npc_op = op;
        imm = im;
        rd1 = r1;
        exec_done = 1'b1;
        step;
        exec_done = 1'b0;
    endtask

    initial begin
        step;
        step;
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc4, 32'h4);
        check("rst_inst", inst, NOP);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_req", {31'b0, req}, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);
        rst_n = 1'b1;
        step;
        check("first_req", {31'b0, req}, 32'h1);
        check("first_addr", addr, 32'h0);
        fetch(32'h0050_0093);
        check("first_inst", inst, 32'h0050_0093);
        check("first_valid", {31'b0, inst_valid}, 32'h1);
        step;
        step;
        check("hold_inst", inst, 32'h0050_0093);
        check("hold_valid", {31'b0, inst_valid}, 32'h1);
        check("hold_req", {31'b0, req}, 32'h0);
        exec(PC_IMM, 32'h10, 32'h0);
        check("jump_0x10", pc, 32'h10);
        fetch(32'h0000_0013);
        exec(PC_4, 32'h0, 32'h0);
        check("pc4_addr", addr, 32'h14);
        check("pc4_pc4", pc4, 32'h18);
        check("pc4_valid_t1", {31'b0, inst_valid}, 32'h0);
        check("pc4_req_t1", {31'b0, req}, 32'h1);
        gnt = 1'b1;
        step;
        gnt = 1'b0;
        check("pc4_valid_t2", {31'b0, inst_valid}, 32'h0);
        rvalid = 1'b1;
        rdata = 32'h0010_0113;
        step;
        rvalid = 1'b0;
        check("pc4_valid_t3", {31'b0, inst_valid}, 32'h1);
        check("pc4_inst", inst, 32'h0010_0113);
        exec(PC_IMM, 32'hC, 32'h0);
        check("to_0x20", pc, 32'h20);
        fetch(32'h1111_1111);
        exec(PC_IMM, 32'hFFFF_FFF8, 32'h0);
        check("neg_imm", pc, 32'h18);
        fetch(32'h2222_2222);
        exec(RD1_IMM, 32'h4, 32'h101);
        check("rd1_imm_pc", pc, 32'h104);
        check("rd1_imm_pc4", pc4, 32'h108);
        fetch(32'h3333_3333);
        exec(2'b11, 32'h5555, 32'h0);
        check("op11", pc, 32'h108);
        fetch(32'h4444_4444);
        exec(PC_IMM, 32'hFFFF_FF38, 32'h0);
        check("to_0x40", pc, 32'h40);
        fetch(32'hA0A0_A0A3);
        exec(PC_IMM, 32'h6, 32'h0);
`ifdef MISALIGN_CHECK_EN
        check("trap_misalign", {31'b0, misalign}, 32'h1);
        check("trap_pc", pc, 32'h40);
        check("trap_valid", {31'b0, inst_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            gnt = 1'b1;
            step;
            check("trap_req", {31'b0, req}, 32'h0);
        end
        gnt = 1'b0;
        rst_n = 1'b0;
        step;
        check("trap_cleared", {31'b0, misalign}, 32'h0);
        rst_n = 1'b1;
        step;
        fetch(32'h5555_5555);
        exec(PC_IMM, 32'h44, 32'h0);
`else
        check("misalign_off", {31'b0, misalign}, 32'h0);
`endif
        check("aligned_pc", pc, 32'h44);
        check("aligned_req", {31'b0, req}, 32'h1);
        exec_done = 1'b1;
        npc_op = PC_IMM;
        imm = 32'h100;
        rvalid = 1'b1;
        rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step;
            check("nognt_req", {31'b0, req}, 32'h1);
            check("nognt_pc", pc, 32'h44);
            check("nognt_valid", {31'b0, inst_valid}, 32'h0);
        end
        exec_done = 1'b0;
        rvalid = 1'b0;
        gnt = 1'b1;
        step;
        check("wait_req", {31'b0, req}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step;
            check("wait_valid", {31'b0, inst_valid}, 32'h0);
            check("wait_inst", inst, last);
            check("wait_req_low", {31'b0, req}, 32'h0);
        end
        gnt = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h1234_5678;
        step;
        rvalid = 1'b0;
        check("late_inst", inst, 32'h1234_5678);
        check("late_valid", {31'b0, inst_valid}, 32'h1);
        check("late_pc", pc, 32'h44);
        exec(PC_4, 32'h0, 32'h0);
        check("pre_rst_pc", pc, 32'h48);
        gnt = 1'b1;
        step;
        gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_pc4", pc4, 32'h4);
        check("mid_rst_inst", inst, NOP);
        check("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
        check("mid_rst_req", {31'b0, req}, 32'h0);
        rvalid = 1'b1;
        rdata = 32'h0BAD_0BAD;
        step;
        rst_n = 1'b1;
        step;
        check("post_rst_inst", inst, NOP);
        check("post_rst_valid", {31'b0, inst_valid}, 32'h0);
        check("post_rst_req", {31'b0, req}, 32'h1);
        check("post_rst_addr", addr, 32'h0);
        rvalid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
